// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution result writer.
//   conv_state_t : writer FSM state encoding
//   o_size()     : output feature-map side length for a given input, filter and stride
//   npix()       : number of output pixels per frame (o_size squared)
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

  function automatic int o_size(input int i_size, input int f_size, input int step);
    return (i_size - f_size) / step + 1;
  endfunction

  function automatic int npix(input int i_size, input int f_size, input int step);
    int o;
    o = o_size(i_size, f_size, step);
    return o * o;
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO holding accepted result beats until the memory port takes them.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   clk_en       : global enable; push/pop only take effect when high
//   push, din    : write request and data (ignored when full)
//   pop, dout    : read request and head-of-queue data (ignored when empty)
//   full, empty  : occupancy flags, derived from registered state only
module result_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & clk_en & ~full;
  assign do_pop  = pop & clk_en & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Writes one frame of convolution results to output memory in raster order.
//   clk, rst_n        : clock, async active-low reset (discards any partial frame)
//   clk_en            : global enable; all state freezes while low
//   start             : begin a frame (honoured in IDLE only)
//   in_valid/in_ready : result-beat handshake, in_data packs FILTERS channels
//   mem_hold          : output memory port unavailable this cycle
//   cenw/aa_out/d_out : registered active-low write strobe, address, data
//   busy, done        : frame in progress / one-cycle end-of-frame pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, no beats accepted
// RUN     | accepting beats into the FIFO and writing them out in raster order
// DONE    | all NPIX writes issued; pulse done, clear coordinates and counts
module conv_result_writer
  import conv_pkg::*;
#(
  parameter  int I_SIZE  = 32,
  parameter  int F_SIZE  = 5,
  parameter  int STEP    = 1,
  parameter  int FILTERS = 6,
  parameter  int D_WIDTH = 8,
  localparam int O_SIZE  = o_size(I_SIZE, F_SIZE, STEP),
  localparam int NPIX    = npix(I_SIZE, F_SIZE, STEP),
  localparam int A_WIDTH = $clog2(NPIX + 1),
  localparam int DW      = FILTERS * D_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_data,
  output logic               in_ready,
  input  logic               mem_hold,
  output logic               cenw,
  output logic [A_WIDTH-1:0] aa_out,
  output logic [DW-1:0]      d_out,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH-1:0] O_SIZE_A = A_WIDTH'(O_SIZE);
  localparam logic [A_WIDTH-1:0] X_MAX_A  = A_WIDTH'(O_SIZE - 1);
  localparam logic [A_WIDTH-1:0] NPIX_A   = A_WIDTH'(NPIX);
  localparam logic [A_WIDTH-1:0] ONE_A    = A_WIDTH'(1);

  conv_state_t        state_q, state_d;
  logic [A_WIDTH-1:0] x_q, x_d;
  logic [A_WIDTH-1:0] y_q, y_d;
  logic [A_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic [A_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic               cenw_q, cenw_d;
  logic [A_WIDTH-1:0] aa_q, aa_d;
  logic [DW-1:0]      dat_q, dat_d;

  logic               fifo_full, fifo_empty;
  logic [DW-1:0]      fifo_dout;
  logic               push, pop;

  // Handshake is built from registered state only, so in_valid never
  // combinationally reaches in_ready.
  assign in_ready = (state_q == ST_RUN) & ~fifo_full & (acc_cnt_q < NPIX_A);
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == ST_RUN) & ~fifo_empty & ~mem_hold;

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign cenw   = cenw_q;
  assign aa_out = aa_q;
  assign d_out  = dat_q;

  result_fifo2 #(.WIDTH(DW)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .push   (push),
    .din    (in_data),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    cenw_d    = cenw_q;
    aa_d      = aa_q;
    dat_d     = dat_q;
    if (clk_en) begin
      cenw_d = 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (push) acc_cnt_d = acc_cnt_q + ONE_A;
          if (pop) begin
            cenw_d   = 1'b0;
            aa_d     = y_q * O_SIZE_A + x_q;
            dat_d    = fifo_dout;
            wr_cnt_d = wr_cnt_q + ONE_A;
            if (x_q == X_MAX_A) begin
              x_d = '0;
              y_d = y_q + ONE_A;
            end else begin
              x_d = x_q + ONE_A;
            end
          end
          // Leave RUN the cycle after the last write is on the port.
          if (wr_cnt_q == NPIX_A) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          x_d       = '0;
          y_d       = '0;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      cenw_q    <= 1'b1;
      aa_q      <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      cenw_q    <= cenw_d;
      aa_q      <= aa_d;
      dat_q     <= dat_d;
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;

  localparam int DW = 48;
  localparam logic [DW-1:0] D2_BASE = 48'h5A00_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clk_en;
  logic          start, in_valid, mem_hold;
  logic [DW-1:0] in_data;
  logic          in_ready, cenw, busy, done;
  logic [4:0]    aa_out;
  logic [DW-1:0] d_out;

  logic          start2, in_valid2, mem_hold2;
  logic [DW-1:0] in_data2;
  logic          in_ready2, cenw2, busy2, done2;
  logic [3:0]    aa2;
  logic [DW-1:0] d2;

  conv_result_writer #(.I_SIZE(6), .F_SIZE(3), .STEP(1), .FILTERS(6), .D_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_hold(mem_hold), .cenw(cenw), .aa_out(aa_out), .d_out(d_out),
    .busy(busy), .done(done)
  );

  conv_result_writer #(.I_SIZE(7), .F_SIZE(3), .STEP(2), .FILTERS(6), .D_WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start2),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .mem_hold(mem_hold2), .cenw(cenw2), .aa_out(aa2), .d_out(d2),
    .busy(busy2), .done(done2)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Write/done monitor: logs every newly issued write (one per enabled edge).
  int            cyc_n = 0;
  logic          en_at_edge = 1'b0;
  int            wr_total = 0, done_total = 0, done_cyc = 0;
  int            obs_addr [256];
  logic [DW-1:0] obs_data [256];
  int            wr_cyc   [256];
  int            w2_total = 0, d2_total = 0, d2_cyc = 0;
  int            obs2_addr [16];
  logic [DW-1:0] obs2_data [16];
  int            w2_cyc    [16];

  always @(posedge clk) begin
    cyc_n      <= cyc_n + 1;
    en_at_edge <= clk_en;
  end

  always @(negedge clk) begin
    if (en_at_edge && rst_n) begin
      if (!cenw && wr_total < 256) begin
        obs_addr[wr_total] <= int'(aa_out);
        obs_data[wr_total] <= d_out;
        wr_cyc[wr_total]   <= cyc_n;
        wr_total           <= wr_total + 1;
      end
      if (done) begin
        done_total <= done_total + 1;
        done_cyc   <= cyc_n;
      end
      if (!cenw2 && w2_total < 16) begin
        obs2_addr[w2_total] <= int'(aa2);
        obs2_data[w2_total] <= d2;
        w2_cyc[w2_total]    <= cyc_n;
        w2_total            <= w2_total + 1;
      end
      if (done2) begin
        d2_total <= d2_total + 1;
        d2_cyc   <= cyc_n;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int beat_idx = 0, beats_to_send = 0;
  int frame_base = 0, done_base = 0, first_acc_cyc = 0;

  task automatic new_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    in_data = r[DW-1:0];
  endtask

  // One clock of stimulus; a beat accepted at this edge is pushed to the scoreboard.
  task automatic cyc();
    logic acc;
    acc = in_valid && in_ready && clk_en && rst_n;
    if (acc) begin
      sb.push_back('{addr: beat_idx, data: in_data});
      if (beat_idx == 0) first_acc_cyc = cyc_n + 1;
    end
    @(posedge clk); #1;
    if (acc) begin
      beat_idx++;
      beats_to_send--;
      new_data();
    end
    in_valid = (beats_to_send > 0);
  endtask

  task automatic begin_frame();
    beat_idx      = 0;
    beats_to_send = 16;
    in_valid      = 1'b1;
    new_data();
    frame_base    = wr_total;
    done_base     = done_total;
    start         = 1'b1;
    cyc();
    start         = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_total == done_base && n < 300) begin
      cyc();
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_total != done_base), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input int n);
    int   k;
    exp_t e;
    k = wr_total - frame_base;
    chk({tag, "_wr_count"}, 64'(k), 64'(n));
    for (int i = 0; i < k; i++) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{addr: -1, data: '0};
      chk({tag, "_addr"}, 64'(obs_addr[frame_base + i]), 64'(e.addr));
      chk({tag, "_data"}, 64'(obs_data[frame_base + i]), 64'(e.data));
    end
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_done_pulses"}, 64'(done_total - done_base), 64'd1);
    if (k > 0) chk({tag, "_done_lat"}, 64'(done_cyc), 64'(wr_cyc[frame_base + k - 1] + 1));
  endtask

  initial begin
    int   n, k0, b2;
    logic saw_nr, acc2;

    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; in_valid = 1'b0; mem_hold = 1'b0;
    in_data = '0; start2 = 1'b0; in_valid2 = 1'b0; mem_hold2 = 1'b0; in_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cenw", 64'(cenw), 64'd1);
    chk("rst_aa", 64'(aa_out), 64'd0);
    chk("rst_d", 64'(d_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // Beats offered before start must not be accepted or written.
    beats_to_send = 16; in_valid = 1'b1; new_data();
    repeat (3) cyc();
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    chk("idle_no_write", 64'(wr_total), 64'd0);
    chk("idle_sb", 64'(sb.size()), 64'd0);

    // Frame 1: back-to-back beats, with a stray start mid-frame.
    begin_frame();
    chk("f1_busy", 64'(busy), 64'd1);
    repeat (6) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("f1_busy_after_start", 64'(busy), 64'd1);
    wait_done("f1");
    check_frame("f1", 16);
    chk("f1_first_lat", 64'(wr_cyc[frame_base]), 64'(first_acc_cyc + 1));
    chk("f1_b2b", 64'(wr_cyc[frame_base + 15] - wr_cyc[frame_base]), 64'd15);

    // Frame 2: memory port held for 3 cycles after the 5th write.
    begin_frame();
    n = 0;
    while (wr_total - frame_base < 5 && n < 100) begin cyc(); n++; end
    mem_hold = 1'b1; saw_nr = 1'b0;
    repeat (3) begin cyc(); if (!in_ready) saw_nr = 1'b1; end
    mem_hold = 1'b0;
    chk("f2_in_ready_low", 64'(saw_nr), 64'd1);
    wait_done("f2");
    check_frame("f2", 16);

    // Frame 3: clk_en low for 4 cycles mid-frame.
    begin_frame();
    n = 0;
    while (wr_total - frame_base < 6 && n < 100) begin cyc(); n++; end
    @(negedge clk); #1;
    k0 = wr_total - frame_base;
    clk_en = 1'b0;
    repeat (4) cyc();
    @(negedge clk); #1;
    chk("f3_frz_writes", 64'(wr_total - frame_base), 64'(k0));
    chk("f3_frz_aa", 64'(aa_out), 64'(k0 - 1));
    chk("f3_frz_busy", 64'(busy), 64'd1);
    chk("f3_frz_in_ready", 64'(in_ready), 64'd1);
    clk_en = 1'b1;
    wait_done("f3");
    check_frame("f3", 16);

    // Frame 4: asynchronous reset after 7 writes, then a fresh frame.
    begin_frame();
    n = 0;
    while (wr_total - frame_base < 7 && n < 100) begin cyc(); n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("f4_rst_cenw", 64'(cenw), 64'd1);
    chk("f4_rst_busy", 64'(busy), 64'd0);
    chk("f4_rst_in_ready", 64'(in_ready), 64'd0);
    chk("f4_rst_aa", 64'(aa_out), 64'd0);
    rst_n = 1'b1;
    sb.delete();
    beats_to_send = 0; in_valid = 1'b0;
    begin_frame();
    wait_done("f5");
    check_frame("f5", 16);
    chk("f5_restart_addr", 64'(obs_addr[frame_base]), 64'd0);

    // Second instance: I_SIZE=7, STEP=2 -> 3x3 output.
    b2 = 0;
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = D2_BASE | DW'(b2);
    n = 0;
    while (d2_total == 0 && n < 200) begin
      acc2 = in_valid2 && in_ready2;
      @(posedge clk); #1;
      if (acc2) begin
        b2++;
        in_data2 = D2_BASE | DW'(b2);
        if (b2 == 9) in_valid2 = 1'b0;
      end
      n++;
    end
    chk("s2_done_seen", 64'(d2_total), 64'd1);
    chk("s2_wr_count", 64'(w2_total), 64'd9);
    chk("s2_fifth_aa", 64'(obs2_addr[4]), 64'd4);
    for (int i = 0; i < w2_total; i++) begin
      chk("s2_addr", 64'(obs2_addr[i]), 64'(i));
      chk("s2_data", 64'(obs2_data[i]), 64'(D2_BASE | DW'(i)));
    end
    if (w2_total > 0) chk("s2_done_lat", 64'(d2_cyc), 64'(w2_cyc[w2_total - 1] + 1));
    chk("s2_busy_after", 64'(busy2), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
